// File: rtl/ack_requester.sv
// Front end for one request line of the shared ACK bus arbiter: counts host
// completions, requests while any are pending, and backs off after each grant.
module ack_requester #(
    parameter int CNT_W   = 3,
    parameter int HOLDOFF = 1,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             done_i,
    input  logic             ack_ready_i,
    input  logic             clr_i,
    output logic             req_o,
    output logic [CNT_W-1:0] pending_o,
    output logic             overflow_o,
    output logic             starve_o
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD
    } state_t;

    state_t            state_reg,    state_next;
    logic [CNT_W-1:0]  pending_reg,  pending_next;
    logic [WAIT_W-1:0] wait_reg,     wait_next;
    logic [HOLD_W-1:0] hold_reg,     hold_next;
    logic              overflow_reg, overflow_next;
    logic              starve_reg,   starve_next;
    logic              grant;
    logic              set_overflow;
    logic              set_starve;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            pending_reg  <= '0;
            wait_reg     <= '0;
            hold_reg     <= '0;
            overflow_reg <= 1'b0;
            starve_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            wait_reg     <= wait_next;
            hold_reg     <= hold_next;
            overflow_reg <= overflow_next;
            starve_reg   <= starve_next;
        end
    end

    always_comb begin
        grant        = (state_reg == ST_REQ) && ack_ready_i;
        pending_next = pending_reg;
        set_overflow = 1'b0;
        set_starve   = 1'b0;
        state_next   = state_reg;
        wait_next    = wait_reg;
        hold_next    = hold_reg;

        // A completion and a grant in the same cycle cancel out.
        if (done_i && !grant) begin
            if (pending_reg == CNT_MAX) begin
                set_overflow = 1'b1;
            end else begin
                pending_next = pending_reg + 1'b1;
            end
        end else if (!done_i && grant) begin
            pending_next = pending_reg - 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (pending_reg != '0) begin
                    state_next = ST_REQ;
                    wait_next  = '0;
                end
            end
            ST_REQ: begin
                if (grant) begin
                    wait_next = '0;
                    if (HOLDOFF > 0) begin
                        state_next = ST_HOLD;
                        hold_next  = HOLD_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (wait_reg != WAIT_MAX) begin
                    // Starvation is flagged once, on the cycle the wait count reaches its limit.
                    wait_next = wait_reg + 1'b1;
                    if (wait_reg == WAIT_MAX - 1'b1) begin
                        set_starve = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    hold_next = hold_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        overflow_next = set_overflow | (overflow_reg & ~clr_i);
        starve_next   = set_starve   | (starve_reg   & ~clr_i);
    end

    assign req_o      = (state_reg == ST_REQ);
    assign pending_o  = pending_reg;
    assign overflow_o = overflow_reg;
    assign starve_o   = starve_reg;

endmodule

// File: doc/ack_requester.md
# ack_requester

Per-module front end that drives one `req_*` line of the shared open-drain ACK bus arbiter. It accumulates completion pulses from its host module (MEM, SHA, AES or CTRL), raises a registered request while completions are pending, and consumes one grant per `ack_ready` cycle. After each grant it drops the request for a holdoff window so lower-priority requesters can win. One instance sits upstream of the arbiter per bus client.

## Interface

Parameters:
- `CNT_W`, 3: pending-counter width; saturates at 2^CNT_W−1.
- `HOLDOFF`, 1: idle cycles forced after each grant. 0 disables the window.
- `TIMEOUT`, 64: consecutive ungranted request cycles before `starve_o` sets. Must be ≥1.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `done_i`  in  1  one-cycle completion pulse from the host module; each high cycle is one event.
- `ack_ready_i`  in  1  grant from the arbiter (`ack_ready_to_*`). Meaningful only while `req_o`=1.
- `clr_i`  in  1  synchronous clear of the sticky flags.
- `req_o`  out  1  request to the arbiter (`req_*`). Registered.
- `pending_o`  out  CNT_W  current pending count.
- `overflow_o`  out  1  sticky; a `done_i` was dropped at saturation.
- `starve_o`  out  1  sticky; the request waited `TIMEOUT` cycles without a grant.

## Operation

- Reset state: state=IDLE, pending=0, wait counter=0, holdoff counter=0.
- Reset values of all outputs: `req_o`=0, `pending_o`=0, `overflow_o`=0, `starve_o`=0.
- `req_o` is high exactly when state==REQ. It is decoded from the state register only, with no combinational path from any input.

Pending counter:
- Increment on `done_i`=1.
- Decrement on a grant, where a grant is state==REQ and `ack_ready_i`=1 at the edge.
- Both in the same cycle: count unchanged.
- `done_i` with count at max and no grant that cycle: count stays at max and `overflow_o` sets.
- A grant with count==0 cannot occur, because REQ is only entered with count>0.

States:
- IDLE:
  - if pending≠0 (registered value) → REQ;
  - else stay.
- REQ:
  - on grant: if HOLDOFF>0 → HOLD, loading the holdoff counter with HOLDOFF−1; if HOLDOFF=0 → IDLE;
  - else stay.
- HOLD:
  - if the holdoff counter ==0 → IDLE;
  - else decrement it.
  - `done_i` is still counted in this state.
- `ack_ready_i` is ignored outside REQ.

Wait counter:
- Width is $clog2(TIMEOUT+1).
- Cleared on entry to REQ and on every grant.
- Increments each cycle in REQ without a grant, and saturates at TIMEOUT.
- When it reaches TIMEOUT, `starve_o` sets.
- The request is never withdrawn because of starvation.

Sticky flags:
- `clr_i`=1 clears `overflow_o` and `starve_o`.
- If a set condition and `clr_i` occur in the same cycle, set wins.
- `clr_i` does not affect pending, the state or any counter.

## Timing

- `done_i` high at edge N (from IDLE, count 0): `pending_o`=1 after N, `req_o`=1 after N+1. Done-to-request latency is 2 cycles.
- The arbiter is combinational, so `ack_ready_i` can be high in the first `req_o` cycle. That grant is consumed at the same edge.
- After a grant at edge G:
  - `req_o`=0 for HOLDOFF+1 cycles (HOLD cycles plus one IDLE cycle);
  - `req_o` re-rises after edge G+HOLDOFF+1 if still pending.
  - With HOLDOFF=0, the minimum gap is one IDLE cycle.
- Back-to-back grants are therefore at most one per HOLDOFF+2 cycles.
- Asynchronous reset mid-REQ: `req_o` drops immediately (not clock-aligned). Pending events are discarded.
- `pending_o` updates at the same edge as the state transition.

## Test plan

- Reset, then a single `done_i` pulse at cycle 5 with `ack_ready_i` tied to `req_o` (defaults):
  - `req_o` high during cycle 7 only;
  - `pending_o` goes 1→0 at edge 7;
  - `req_o` stays low afterward.
- Three `done_i` pulses at cycles 2–4, always granted, HOLDOFF=1: three one-cycle `req_o` pulses spaced 3 cycles apart; `pending_o` ends at 0.
- CNT_W=2, `ack_ready_i`=0, eight `done_i` pulses:
  - `pending_o` saturates at 3;
  - `overflow_o`=1 from the fourth pulse;
  - `clr_i` clears it while `pending_o` stays 3.
- TIMEOUT=4, `ack_ready_i`=0 with pending=1:
  - `starve_o` rises after 4 ungranted REQ cycles;
  - `req_o` stays high;
  - a later grant drops `req_o`, and `starve_o` remains set until `clr_i`.
- Simultaneous `done_i` and grant with pending=1: `pending_o` stays 1, state goes to HOLD, and `req_o` re-asserts after the holdoff.
- `rst_n` asserted asynchronously mid-REQ with pending=2: `req_o`, `pending_o` and both flags are 0 immediately; no request follows release of reset.
